// File: rtl/ofdm_frame_pkg.sv
// Shared OFDM burst framing constants, slot map and framer state type.
package ofdm_frame_pkg;

  localparam int DATA_W     = 8;
  localparam int FFT_POINT  = 64;
  localparam int CP_NUM     = 16;
  localparam int SYMBOL_NUM = 8;

  localparam int SLOT      = FFT_POINT + CP_NUM;
  localparam int NUM_SLOTS = 6 + SYMBOL_NUM;
  localparam int IN_SIZE   = (4 + SYMBOL_NUM) * FFT_POINT;
  localparam int BURST     = NUM_SLOTS * SLOT;

  localparam int ADDR_W = $clog2(IN_SIZE);
  localparam int IDX_W  = $clog2(BURST);

  typedef enum logic {SYM, PAD} slot_kind_e;

  typedef struct packed {
    slot_kind_e kind;
    logic [3:0] sym;
  } slot_map_t;

  typedef enum logic [1:0] {FILL, PRIME, SEND, DONE} frm_state_e;

  // Preamble interleaves two zero-pad slots between the sync/CE symbols.
  function automatic slot_map_t slot_map(input logic [3:0] slot);
    slot_map_t m;
    m.kind = SYM;
    m.sym  = 4'd0;
    case (slot)
      4'd0:    m.sym  = 4'd0;
      4'd1:    m.sym  = 4'd1;
      4'd2:    m.kind = PAD;
      4'd3:    m.sym  = 4'd2;
      4'd4:    m.kind = PAD;
      4'd5:    m.sym  = 4'd3;
      default: m.sym  = slot - 4'd2;
    endcase
    return m;
  endfunction

  // p<16 reads the symbol tail (48+p), otherwise p-16; both equal p+48 mod 64.
  function automatic logic [ADDR_W-1:0] sym_addr(input logic [3:0] sym,
                                                 input logic [5:0] pos);
    logic [5:0] off;
    off = pos + 6'd48;
    return {sym, off};
  endfunction

endpackage

// File: rtl/tx_sample_ram.sv
// Burst sample buffer: one write port, one registered read port (block RAM).
module tx_sample_ram
  import ofdm_frame_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int DEPTH = IN_SIZE,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port and registered read; rdata holds when re is low.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/ofdm_tx_framer.sv
// Transmit burst framer: buffers 768 IFFT samples, emits a 1120-sample burst
// with cyclic prefix on every symbol and zero pad slots in the preamble.
//
// state | meaning
// FILL  | accepting din into the buffer
// PRIME | buffer full, first read issued
// SEND  | streaming burst samples
// DONE  | one-cycle tx_done, counters cleared
module ofdm_tx_framer
  import ofdm_frame_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wren,
  output logic              in_full,
  output logic              in_overrun,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              tx_done
);

  localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(IN_SIZE - 1);
  localparam logic [6:0]        POS_LAST  = 7'(SLOT - 1);
  localparam logic [3:0]        SLOT_LAST = 4'(NUM_SLOTS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BURST - 1);

  frm_state_e state_q, state_d;

  logic [ADDR_W-1:0] cnt_in_q;
  logic [3:0]        slot_q;
  logic [6:0]        pos_q;
  logic [IDX_W-1:0]  idx_q;

  logic valid_q, pad_q, last_q, overrun_q;

  logic              wr_en, rd_issue, rd_en, xfer;
  slot_map_t         cur_map;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_q;

  assign xfer     = valid_q & dout_ready;
  assign wr_en    = (state_q == FILL) & wren;
  assign cur_map  = slot_map(slot_q);
  assign rd_addr  = sym_addr(cur_map.sym, pos_q[5:0]);
  // In SEND the output register is always full, so a new read goes out only
  // when the current beat leaves and the last index has not been issued yet.
  assign rd_issue = (state_q == PRIME) |
                    ((state_q == SEND) & (!valid_q | dout_ready) & !last_q);
  assign rd_en    = rd_issue & (cur_map.kind == SYM);

  tx_sample_ram #(
    .DW   (DATA_W),
    .DEPTH(IN_SIZE),
    .AW   (ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(cnt_in_q),
    .wdata(din),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(ram_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= FILL;
    else
      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (wren && cnt_in_q == CNT_LAST) state_d = PRIME;
      PRIME:   state_d = SEND;
      SEND:    if (xfer && last_q) state_d = DONE;
      DONE:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Output decode; pad beats and idle cycles force dout to zero.
  always_comb begin
    in_full    = (state_q == PRIME) | (state_q == SEND);
    tx_done    = (state_q == DONE);
    dout_valid = valid_q;
    dout_last  = valid_q & last_q;
    dout       = (valid_q & !pad_q) ? ram_q : '0;
    in_overrun = overrun_q;
  end

  // Input write counter, wraps at the 768th write.
  always_ff @(posedge clk) begin
    if (rst || state_q == DONE)
      cnt_in_q <= '0;
    else if (wr_en)
      cnt_in_q <= (cnt_in_q == CNT_LAST) ? '0 : cnt_in_q + 1'b1;
  end

  // Read-side slot/position/burst-index counters, advanced per issued read.
  always_ff @(posedge clk) begin
    if (rst || state_q == DONE) begin
      slot_q <= '0;
      pos_q  <= '0;
      idx_q  <= '0;
    end else if (rd_issue) begin
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (pos_q == POS_LAST) begin
        pos_q  <= '0;
        slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
      end else begin
        pos_q <= pos_q + 1'b1;
      end
    end
  end

  // Output register: valid/pad/last track the RAM read issued one cycle earlier.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pad_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (rd_issue) begin
      valid_q <= 1'b1;
      pad_q   <= (cur_map.kind == PAD);
      last_q  <= (idx_q == IDX_LAST);
    end else if (xfer) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  // Sticky flag for writes attempted while the buffer is busy.
  always_ff @(posedge clk) begin
    if (rst)
      overrun_q <= 1'b0;
    else if (wren && state_q != FILL)
      overrun_q <= 1'b1;
  end

endmodule
